// File: rtl/hdmi_timing_pkg.sv
// Shared definitions for the HDMI raster timing generator: CEA-861 mode
// constants and the run/idle state encoding.
package hdmi_timing_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } mode_t;

    localparam mode_t MODE_720X480P60 = '{
        h_active: 720, h_fp: 16, h_sync: 62, h_bp: 60,
        v_active: 480, v_fp: 9,  v_sync: 6,  v_bp: 30
    };

    // Bring-up mode (25.175 MHz pixel clock).
    localparam mode_t MODE_640X480P60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: position counter with exact terminal compare. active and
// sync_asserted decode the value pos takes at the next edge.
module timing_axis
    import hdmi_timing_pkg::*;
#(
    parameter int ACTIVE = 720,
    parameter int FP     = 16,
    parameter int SYNC   = 62,
    parameter int BP     = 60,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    input  logic         clear,
    output logic [W-1:0] pos,
    output logic         at_last,
    output logic         active,
    output logic         sync_asserted
);

    localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_STOP  = ACTIVE + FP + SYNC;
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] pos_next;

    assign at_last = (pos == LAST);

    always_comb begin
        pos_next = pos;
        if (clear) begin
            pos_next = '0;
        end else if (advance) begin
            pos_next = at_last ? '0 : pos + 1'b1;
        end
    end

    assign active        = (32'(pos_next) < 32'(ACTIVE));
    assign sync_asserted = (32'(pos_next) >= 32'(SYNC_START)) &&
                           (32'(pos_next) <  32'(SYNC_STOP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else begin
            pos <= pos_next;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: counters, syncs, DE and line/frame
// markers, all registered so every output describes the same pixel.
module video_timing_gen
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE        = MODE_720X480P60.h_active,
    parameter int H_FP            = MODE_720X480P60.h_fp,
    parameter int H_SYNC          = MODE_720X480P60.h_sync,
    parameter int H_BP            = MODE_720X480P60.h_bp,
    parameter int V_ACTIVE        = MODE_720X480P60.v_active,
    parameter int V_FP            = MODE_720X480P60.v_fp,
    parameter int V_SYNC          = MODE_720X480P60.v_sync,
    parameter int V_BP            = MODE_720X480P60.v_bp,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int POS_W           = 10
) (
    input  logic             pixelClock,
    input  logic             reset,
    input  logic             enable,
    output logic [POS_W-1:0] hPosCounter,
    output logic [POS_W-1:0] vPosCounter,
    output logic             hSync,
    output logic             vSync,
    output logic             inActiveDisplay,
    output logic             lineStart,
    output logic             frameStart,
    output logic             running
);

    localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;
    localparam logic SYNC_ON  = !SYNC_ACTIVE_LOW;

    state_t state, state_next;
    logic   run_next;
    logic   h_last, v_last;
    logic   h_active, v_active;
    logic   h_sync, v_sync;
    logic   new_line, new_frame;

    timing_axis #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(POS_W)
    ) u_h_axis (
        .clk          (pixelClock),
        .rst          (reset),
        .advance      (state == ST_RUN),
        .clear        (!run_next),
        .pos          (hPosCounter),
        .at_last      (h_last),
        .active       (h_active),
        .sync_asserted(h_sync)
    );

    timing_axis #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(POS_W)
    ) u_v_axis (
        .clk          (pixelClock),
        .rst          (reset),
        .advance      ((state == ST_RUN) && h_last),
        .clear        (!run_next),
        .pos          (vPosCounter),
        .at_last      (v_last),
        .active       (v_active),
        .sync_asserted(v_sync)
    );

    // enable only matters in IDLE or on the last pixel of a frame.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (enable) state_next = ST_RUN;
            ST_RUN:  if (h_last && v_last && !enable) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign run_next  = (state_next == ST_RUN);
    assign new_line  = run_next && ((state == ST_IDLE) || h_last);
    assign new_frame = run_next && ((state == ST_IDLE) || (h_last && v_last));
    assign running   = (state == ST_RUN);

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            hSync           <= SYNC_OFF;
            vSync           <= SYNC_OFF;
            inActiveDisplay <= 1'b0;
            lineStart       <= 1'b0;
            frameStart      <= 1'b0;
        end else begin
            hSync           <= (run_next && h_sync) ? SYNC_ON : SYNC_OFF;
            vSync           <= (run_next && v_sync) ? SYNC_ON : SYNC_OFF;
            inActiveDisplay <= run_next && h_active && v_active;
            lineStart       <= new_line;
            frameStart      <= new_frame;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (default mode, a medium mode
// for whole-frame checks, a tiny active-high-sync mode), each compared per
// cycle against a reference model through an expected queue.
module tb_video_timing_gen;

    typedef struct packed {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
        bit sal;
    } cfg_t;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic hs; logic vs; logic de; logic ls; logic fs; logic run;
    } obs_t;

    typedef struct packed {
        bit run; int h; int v;
    } mstate_t;

    localparam cfg_t CFG_D = '{ha:720, hfp:16, hs:62, hbp:60, va:480, vfp:9, vs:6, vbp:30, sal:1'b1};
    localparam cfg_t CFG_A = '{ha:16, hfp:2, hs:3, hbp:3, va:8, vfp:2, vs:2, vbp:2, sal:1'b1};
    localparam cfg_t CFG_B = '{ha:4, hfp:1, hs:2, hbp:1, va:3, vfp:1, vs:1, vbp:1, sal:1'b0};

    logic clk = 1'b0;
    logic rst;
    logic en_d = 1'b0, en_a = 1'b0, en_b = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [9:0] d_h, d_v, a_h, a_v, b_h, b_v;
    logic d_hs, d_vs, d_de, d_ls, d_fs, d_run;
    logic a_hs, a_vs, a_de, a_ls, a_fs, a_run;
    logic b_hs, b_vs, b_de, b_ls, b_fs, b_run;
    obs_t obs_d, obs_a, obs_b;

    obs_t exp_d_q[$];
    obs_t exp_a_q[$];
    obs_t exp_b_q[$];
    mstate_t md = '0, ma = '0, mb = '0;

    assign obs_d = {d_h, d_v, d_hs, d_vs, d_de, d_ls, d_fs, d_run};
    assign obs_a = {a_h, a_v, a_hs, a_vs, a_de, a_ls, a_fs, a_run};
    assign obs_b = {b_h, b_v, b_hs, b_vs, b_de, b_ls, b_fs, b_run};

    always #5 clk = ~clk;

    // ---------------- DUT instances ----------------
    video_timing_gen u_dut_d (
        .pixelClock(clk), .reset(rst), .enable(en_d),
        .hPosCounter(d_h), .vPosCounter(d_v), .hSync(d_hs), .vSync(d_vs),
        .inActiveDisplay(d_de), .lineStart(d_ls), .frameStart(d_fs), .running(d_run)
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_ACTIVE_LOW(1'b1), .POS_W(10)
    ) u_dut_a (
        .pixelClock(clk), .reset(rst), .enable(en_a),
        .hPosCounter(a_h), .vPosCounter(a_v), .hSync(a_hs), .vSync(a_vs),
        .inActiveDisplay(a_de), .lineStart(a_ls), .frameStart(a_fs), .running(a_run)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE_LOW(1'b0), .POS_W(10)
    ) u_dut_b (
        .pixelClock(clk), .reset(rst), .enable(en_b),
        .hPosCounter(b_h), .vPosCounter(b_v), .hSync(b_hs), .vSync(b_vs),
        .inActiveDisplay(b_de), .lineStart(b_ls), .frameStart(b_fs), .running(b_run)
    );

    // ---------------- reference model ----------------
    function automatic mstate_t model_next(input mstate_t m, input logic en, input cfg_t c);
        mstate_t n;
        int ht, vt;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        n = m;
        if (!m.run) begin
            if (en) n = '{run: 1'b1, h: 0, v: 0};
        end else if (m.h == ht - 1) begin
            n.h = 0;
            if (m.v == vt - 1) begin
                n.v = 0;
                n.run = en;
            end else begin
                n.v = m.v + 1;
            end
        end else begin
            n.h = m.h + 1;
        end
        return n;
    endfunction

    function automatic obs_t model_obs(input mstate_t m, input cfg_t c);
        obs_t o;
        bit in_hs, in_vs;
        o = '0;
        if (!m.run) begin
            o.hs = c.sal;
            o.vs = c.sal;
        end else begin
            in_hs = (m.h >= c.ha + c.hfp) && (m.h < c.ha + c.hfp + c.hs);
            in_vs = (m.v >= c.va + c.vfp) && (m.v < c.va + c.vfp + c.vs);
            o.h   = 10'(m.h);
            o.v   = 10'(m.v);
            o.hs  = in_hs ^ c.sal;
            o.vs  = in_vs ^ c.sal;
            o.de  = (m.h < c.ha) && (m.v < c.va);
            o.ls  = (m.h == 0);
            o.fs  = (m.h == 0) && (m.v == 0);
            o.run = 1'b1;
        end
        return o;
    endfunction

    // Expected values are pushed only on clock edges; a reset edge just
    // clears the model state.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md = '0; ma = '0; mb = '0;
        end else begin
            md = model_next(md, en_d, CFG_D);
            ma = model_next(ma, en_a, CFG_A);
            mb = model_next(mb, en_b, CFG_B);
        end
        if (clk) begin
            exp_d_q.push_back(model_obs(md, CFG_D));
            exp_a_q.push_back(model_obs(ma, CFG_A));
            exp_b_q.push_back(model_obs(mb, CFG_B));
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b run=%b, expected h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b run=%b",
                     name, $time, act.h, act.v, act.hs, act.vs, act.de, act.ls, act.fs, act.run,
                     exp.h, exp.v, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.run);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_d_q.size() > 0) check_obs("dut_d", obs_d, exp_d_q.pop_front());
        if (exp_a_q.size() > 0) check_obs("dut_a", obs_a, exp_a_q.pop_front());
        if (exp_b_q.size() > 0) check_obs("dut_b", obs_b, exp_b_q.pop_front());
    end

    // Frame-level properties of the medium instance: 24x14 total, 16x8 active.
    int a_cyc = 0, a_ls_cyc = 0, a_de_n = 0, a_hs_n = 0, a_vs_n = 0;
    int a_maxh = 0, a_maxv = 0;
    bit a_have = 1'b0, a_ls_have = 1'b0;

    always @(negedge clk) begin
        if (a_run !== 1'b1) begin
            a_have = 1'b0;
            a_ls_have = 1'b0;
        end else begin
            if (a_fs) begin
                if (a_have) begin
                    check_val("a_frame_period", a_cyc, 336);
                    check_val("a_de_per_frame", a_de_n, 128);
                    check_val("a_hsync_per_frame", a_hs_n, 42);
                    check_val("a_vsync_per_frame", a_vs_n, 48);
                end
                a_have = 1'b1;
                a_cyc = 0; a_de_n = 0; a_hs_n = 0; a_vs_n = 0;
            end
            if (a_ls) begin
                if (a_ls_have) check_val("a_line_period", a_ls_cyc, 24);
                a_ls_have = 1'b1;
                a_ls_cyc = 0;
            end
            a_cyc++;
            a_ls_cyc++;
            if (a_de) a_de_n++;
            if (!a_hs) a_hs_n++;
            if (!a_vs) a_vs_n++;
            if (int'(a_h) > a_maxh) a_maxh = int'(a_h);
            if (int'(a_v) > a_maxv) a_maxv = int'(a_v);
        end
    end

    // Default mode: hsync low exactly on h=736..797, 62 cycles per 858-cycle line.
    int d_ls_cyc = 0, d_hs_n = 0;
    bit d_ls_have = 1'b0;

    always @(negedge clk) begin
        if (d_run !== 1'b1) begin
            d_ls_have = 1'b0;
        end else begin
            if (d_ls) begin
                if (d_ls_have) begin
                    check_val("d_line_period", d_ls_cyc, 858);
                    check_val("d_hsync_per_line", d_hs_n, 62);
                end
                d_ls_have = 1'b1;
                d_ls_cyc = 0;
                d_hs_n = 0;
            end
            d_ls_cyc++;
            if (!d_hs) begin
                d_hs_n++;
                check_val("d_hsync_pos", int'(d_h >= 10'd736 && d_h <= 10'd797), 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_pos_a(input int h, input int v);
        int n;
        n = 0;
        @(negedge clk);
        while (!(int'(a_h) == h && int'(a_v) == v) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_val("wait_a_pos_timeout", 0, 1);
    endtask

    int fs_seen;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Idle with enable low.
        repeat (1000) @(negedge clk);
        check_val("d_idle_hsync", int'(d_hs), 1);
        check_val("d_idle_vsync", int'(d_vs), 1);
        check_val("d_idle_running", int'(d_run), 0);
        check_val("d_idle_de", int'(d_de), 0);

        // Start default and tiny instances; (0,0) appears after one edge.
        #1;
        en_d = 1'b1;
        en_b = 1'b1;
        @(negedge clk);
        check_val("d_start_h", int'(d_h), 0);
        check_val("d_start_v", int'(d_v), 0);
        check_val("d_start_de", int'(d_de), 1);
        check_val("d_start_fs", int'(d_fs), 1);
        check_val("d_start_ls", int'(d_ls), 1);
        check_val("d_start_running", int'(d_run), 1);
        repeat (3 * 858) @(negedge clk);

        // Medium instance: two free-running frames.
        #1 en_a = 1'b1;
        repeat (2 * 336 + 5) @(negedge clk);

        // Mid-frame toggle of enable has no effect.
        wait_pos_a(5, 3);
        #1 en_a = 1'b0;
        wait_pos_a(10, 6);
        #1 en_a = 1'b1;
        repeat (2 * 336) @(negedge clk);
        check_val("a_toggle_running", int'(a_run), 1);

        // Drop enable and keep it low: frame completes, then idle.
        wait_pos_a(5, 3);
        #1 en_a = 1'b0;
        wait_pos_a(23, 13);
        check_val("a_last_running", int'(a_run), 1);
        @(negedge clk);
        check_val("a_stop_running", int'(a_run), 0);
        check_val("a_stop_h", int'(a_h), 0);
        check_val("a_stop_v", int'(a_v), 0);
        check_val("a_stop_hsync", int'(a_hs), 1);
        fs_seen = 0;
        repeat (400) begin
            @(negedge clk);
            if (a_fs) fs_seen++;
        end
        check_val("a_no_frame_after_stop", fs_seen, 0);

        // Reset mid-frame with enable held high.
        #1 en_a = 1'b1;
        wait_pos_a(7, 4);
        #1 rst = 1'b1;
        #1;
        check_val("a_rst_running", int'(a_run), 0);
        check_val("a_rst_h", int'(a_h), 0);
        check_val("a_rst_v", int'(a_v), 0);
        check_val("a_rst_hsync", int'(a_hs), 1);
        check_val("a_rst_vsync", int'(a_vs), 1);
        check_val("a_rst_de", int'(a_de), 0);
        check_val("a_rst_fs", int'(a_fs), 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("a_restart_h", int'(a_h), 0);
        check_val("a_restart_v", int'(a_v), 0);
        check_val("a_restart_fs", int'(a_fs), 1);
        check_val("a_restart_running", int'(a_run), 1);

        repeat (3 * 336) @(negedge clk);
        check_val("a_max_h", a_maxh, 23);
        check_val("a_max_v", a_maxv, 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Free-running raster timing generator for the HDMI transmit path. It produces the pixel coordinates, the sync pulses, the active-display strobe and the line/frame markers that the TMDS transmitter and the pixel and audio sources consume. All outputs are registered and mutually coherent: on any cycle they describe the same pixel. Defaults give CEA-861 720x480p60 (858x525 total, 27 MHz pixel clock).

## Interface
- H_ACTIVE, 720, active pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 62, horizontal sync width in pixels
- H_BP, 60, horizontal back porch in pixels
- V_ACTIVE, 480, active lines per frame
- V_FP, 9, vertical front porch in lines
- V_SYNC, 6, vertical sync width in lines
- V_BP, 30, vertical back porch in lines
- SYNC_ACTIVE_LOW, 1, when 1 the asserted level of hSync/vSync is 0
- POS_W, 10, width of the position outputs; must hold H_TOTAL-1 and V_TOTAL-1
- pixelClock  input  1  pixel clock, the only clock
- reset  input  1  asynchronous, active-high
- enable  input  1  run request; sampled every pixelClock
- hPosCounter  output  POS_W  current pixel column
- vPosCounter  output  POS_W  current line
- hSync  output  1  horizontal sync, at the polarity set by SYNC_ACTIVE_LOW
- vSync  output  1  vertical sync, at the polarity set by SYNC_ACTIVE_LOW
- inActiveDisplay  output  1  DE; high for active pixels only
- lineStart  output  1  one-cycle pulse at hPosCounter==0 while running
- frameStart  output  1  one-cycle pulse at (0,0) while running
- running  output  1  high in the RUN state

## Operation
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- The FSM has two states, IDLE and RUN.
- IDLE:
  - outputs are held at their reset values.
  - When enable=1, the next edge enters RUN and presents pixel (0,0) with inActiveDisplay=1, lineStart=1, frameStart=1.
- RUN: each edge advances hPosCounter.
  - At hPosCounter==H_TOTAL-1, hPosCounter wraps to 0 and vPosCounter increments.
  - At vPosCounter==V_TOTAL-1 on the same edge, vPosCounter wraps to 0.
- Stop rule:
  - enable is evaluated only at the last pixel (H_TOTAL-1, V_TOTAL-1).
  - If enable=0 there, the next edge returns to IDLE. Otherwise the next edge gives (0,0) and a new frame.
  - A frame is never truncated. Toggling enable mid-frame has no effect.
- Output decode is a function of the coordinates presented on the same cycle:
  - inActiveDisplay = h<H_ACTIVE && v<V_ACTIVE.
  - hSync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vSync is asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] over whole lines, edges aligned to h==0 (progressive).
- Decode uses the next-state counter values, registered alongside the counters. There is no cycle of skew between the position and the strobe outputs.
- Counters use exact compare-to-terminal logic. Values ≥ TOTAL are never produced.

## Timing
- Reset values:
  - hPosCounter=0, vPosCounter=0.
  - inActiveDisplay=0, lineStart=0, frameStart=0, running=0.
  - hSync and vSync at the deasserted level: 1 when SYNC_ACTIVE_LOW=1, 0 otherwise.
- Reset asserted mid-frame forces these values asynchronously. After release, the first edge with enable=1 starts a fresh frame at (0,0).
- Latency from enable to pixel (0,0) is 1 edge from IDLE.
- frameStart period: H_TOTAL×V_TOTAL cycles (450450 at defaults).
- lineStart period: H_TOTAL cycles.
- Active-pixel count per frame: H_ACTIVE×V_ACTIVE (345600 at defaults).

## Structure
- Package hdmi_timing_pkg holds:
  - the CEA-861 mode constants (720x480p60 set, plus 640x480p60 for bring-up);
  - the FSM state encoding (IDLE, RUN).
- One sub-module, timing_axis, is instantiated twice, for horizontal and vertical.
  - It is parameterized by ACTIVE/FP/SYNC/BP and W.
  - Inputs: advance, clear.
  - Outputs: pos, at_last, active, sync_asserted.
  - The vertical instance advances on the horizontal at_last.
  - The top level owns the FSM, polarity, strobes and output registers.

## Test plan
- Reset with enable=0 -> all outputs at reset values (hSync=vSync=1 at defaults), running=0 for 1000 cycles.
- enable=1 from IDLE -> next edge shows (0,0), inActiveDisplay=1, frameStart=1, lineStart=1.
  - hSync=0 exactly at h=736..797 (62 cycles) on every line.
  - vSync=0 exactly on lines 489..494.
- Free-run of 2 frames:
  - frameStart spacing is 450450 cycles and lineStart spacing is 858 cycles.
  - 345600 DE cycles per frame.
  - Coordinates never exceed (857, 524).
- Drop enable at (100, 200) and raise it at (500, 300) -> no disturbance.
- Drop enable at (100, 200) and keep it low -> the frame completes to (857, 524), the next edge is IDLE with reset values, and no frameStart follows.
- Assert reset at (400, 250) for 3 cycles with enable=1 held -> outputs take reset values immediately, and the first edge after release shows (0,0) with frameStart=1.
- Small parameters (H 4/1/2/1, V 3/1/1/1, SYNC_ACTIVE_LOW=0) -> exhaustive per-cycle comparison against a reference model over 3 frames.
